// File: rtl/video_stream_gen_if.sv
// Pixel-stream bundle (vsync/href/clken + RGB565 data + target mask) between the
// video source and its consumers.
interface video_stream_gen_if;
    logic        frame_vsync;
    logic        frame_href;
    logic        frame_clken;
    logic [15:0] frame_data;
    logic        frame_mask;
    logic        frame_done;

    modport master (
        output frame_vsync, frame_href, frame_clken, frame_data, frame_mask, frame_done
    );

    modport slave (
        input frame_vsync, frame_href, frame_clken, frame_data, frame_mask, frame_done
    );
endinterface

// File: rtl/video_stream_gen.sv
// Colour-bar video source with a 1-bit target mask on the vsync/href/clken protocol.
// Define VIDEO_STREAM_GEN_BOX_MOVE_EN to make the target bounce; otherwise it sits centred.
module video_stream_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CLKEN_DIV  = 1,
    parameter int H_BLANK    = 16,
    parameter int V_FRONT    = 8,
    parameter int V_BACK     = 8,
    parameter int V_BLANK    = 64,
    parameter int BOX_SIZE   = 64,
    parameter int BOX_STEP   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gen_en,
    video_stream_gen_if.master vid
);

    localparam int BAR_W = (IMG_WIDTH / 8 > 0) ? IMG_WIDTH / 8 : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_ACTIVE,
        S_HBLANK,
        S_BACK,
        S_VBLANK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_div, w_div_nxt;
    logic [10:0] r_x, w_x_nxt;
    logic [10:0] r_y, w_y_nxt;
    logic [10:0] w_bx, w_by;

    logic        r_vsync, r_href, r_clken, r_mask, r_done;
    logic [15:0] r_data;
    logic        w_vsync, w_href, w_clken, w_mask, w_done;
    logic [15:0] w_data;

    function automatic logic [15:0] bar_colour(input logic [10:0] x);
        logic [10:0] b;
        b = x / 11'(BAR_W);
        case (b)
            11'd0:   return 16'hFFFF;
            11'd1:   return 16'hFFE0;
            11'd2:   return 16'h07FF;
            11'd3:   return 16'h07E0;
            11'd4:   return 16'hF81F;
            11'd5:   return 16'hF800;
            11'd6:   return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic in_box(input logic [10:0] x, input logic [10:0] y,
                                    input logic [10:0] bx, input logic [10:0] by);
        logic [11:0] xe, ye;
        xe = {1'b0, bx} + 12'(BOX_SIZE);
        ye = {1'b0, by} + 12'(BOX_SIZE);
        return (x >= bx) && ({1'b0, x} < xe) && (y >= by) && ({1'b0, y} < ye);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (gen_en) w_state_nxt = S_FRONT;
            end
            S_FRONT: begin
                w_x_nxt   = '0;
                w_y_nxt   = '0;
                w_div_nxt = '0;
                if (r_cnt == 32'(V_FRONT - 1)) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_ACTIVE: begin
                if (r_div == 32'(CLKEN_DIV - 1)) begin
                    w_div_nxt = '0;
                    if (r_x == 11'(IMG_WIDTH - 1)) begin
                        w_x_nxt = '0;
                        // Last line skips HBLANK and goes straight to the back porch.
                        if (r_y == 11'(IMG_HEIGHT - 1)) begin
                            w_state_nxt = S_BACK;
                        end else begin
                            w_state_nxt = S_HBLANK;
                            w_y_nxt     = r_y + 11'd1;
                        end
                    end else begin
                        w_x_nxt = r_x + 11'd1;
                    end
                end else begin
                    w_div_nxt = r_div + 32'd1;
                end
            end
            S_HBLANK: begin
                w_div_nxt = '0;
                if (r_cnt == 32'(H_BLANK - 1)) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_BACK: begin
                if (r_cnt == 32'(V_BACK - 1)) begin
                    w_state_nxt = S_VBLANK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_VBLANK: begin
                if (r_cnt == 32'(V_BLANK - 1)) begin
                    w_state_nxt = gen_en ? S_FRONT : S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so every output lands on the same edge as the state.
    always_comb begin
        w_vsync = (w_state_nxt == S_FRONT) || (w_state_nxt == S_ACTIVE) ||
                  (w_state_nxt == S_HBLANK) || (w_state_nxt == S_BACK);
        w_href  = (w_state_nxt == S_ACTIVE);
        w_clken = w_href && (w_div_nxt == 32'd0);
        w_mask  = w_href && in_box(w_x_nxt, w_y_nxt, w_bx, w_by);
        w_data  = 16'h0000;
        if (w_href) w_data = w_mask ? 16'hFFFF : bar_colour(w_x_nxt);
        w_done  = (r_state == S_BACK) && (w_state_nxt == S_VBLANK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_clken <= 1'b0;
            r_mask  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_vsync <= w_vsync;
            r_href  <= w_href;
            r_clken <= w_clken;
            r_mask  <= w_mask;
            r_done  <= w_done;
            r_data  <= w_data;
        end
    end

`ifdef VIDEO_STREAM_GEN_BOX_MOVE_EN
    // Returns {dir_neg, pos}: steps one axis, clamping at either wall and reversing on overshoot.
    function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir_neg,
                                              input logic [10:0] lim);
        logic [11:0] sum;
        if (!dir_neg) begin
            sum = {1'b0, pos} + 12'(BOX_STEP);
            if (sum > {1'b0, lim}) return {1'b1, lim};
            return {1'b0, sum[10:0]};
        end
        if ({1'b0, pos} < 12'(BOX_STEP)) return {1'b0, 11'd0};
        return {1'b1, pos - 11'(BOX_STEP)};
    endfunction

    logic [10:0] r_bx, r_by;
    logic        r_dx_neg, r_dy_neg;
    logic [11:0] w_step_x, w_step_y;

    assign w_step_x = step_axis(r_bx, r_dx_neg, 11'(IMG_WIDTH - BOX_SIZE));
    assign w_step_y = step_axis(r_by, r_dy_neg, 11'(IMG_HEIGHT - BOX_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx     <= '0;
            r_by     <= '0;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
        end else if (w_done) begin
            {r_dx_neg, r_bx} <= w_step_x;
            {r_dy_neg, r_by} <= w_step_y;
        end
    end

    assign w_bx = r_bx;
    assign w_by = r_by;
`else
    assign w_bx = 11'((IMG_WIDTH - BOX_SIZE) / 2);
    assign w_by = 11'((IMG_HEIGHT - BOX_SIZE) / 2);
`endif

    assign vid.frame_vsync = r_vsync;
    assign vid.frame_href  = r_href;
    assign vid.frame_clken = r_clken;
    assign vid.frame_data  = r_data;
    assign vid.frame_mask  = r_mask;
    assign vid.frame_done  = r_done;

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen on a 16x8 frame: timing, bars, target box, stop and reset.
module tb_video_stream_gen;

    localparam int W    = 16;
    localparam int H    = 8;
    localparam int HB   = 4;
    localparam int VF   = 3;
    localparam int VB   = 3;
    localparam int VBL  = 10;
    localparam int BOX  = 4;
    localparam int STEP = 5;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic gen_en = 1'b0;

    video_stream_gen_if vid ();

    video_stream_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .CLKEN_DIV (1),
        .H_BLANK   (HB),
        .V_FRONT   (VF),
        .V_BACK    (VB),
        .V_BLANK   (VBL),
        .BOX_SIZE  (BOX),
        .BOX_STEP  (STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gen_en(gen_en),
        .vid   (vid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] colours [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`ifdef VIDEO_STREAM_GEN_BOX_MOVE_EN
    int exp_bx [9] = '{0, 5, 10, 12, 7, 2, 0, 5, 10};
    int exp_by [9] = '{0, 4, 0, 4, 0, 4, 0, 4, 0};
`else
    int exp_bx [9] = '{6, 6, 6, 6, 6, 6, 6, 6, 6};
    int exp_by [9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
`endif

    logic [15:0] pix [H][W];
    logic        msk [H][W];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int all_outs();
        return 32'({vid.frame_vsync, vid.frame_href, vid.frame_clken,
                    vid.frame_mask, vid.frame_done, vid.frame_data});
    endfunction

    task automatic run_frame(input int fidx, input int stop_line, input bit expect_next);
        int t, vs_len, lines, hlen, xi, gap, len_err, gap_err, idle_err;
        int clk_total, low_len, done_cnt, mcnt, pix_err, bx, by, lim, bar;
        logic prev_href, em;
        logic [15:0] ed;
        t = 0;
        while (vid.frame_vsync !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (vid.frame_vsync !== 1'b1) begin
            chk("vs_start", 32'(vid.frame_vsync), 1);
            return;
        end
        vs_len = 0; lines = 0; hlen = 0; xi = 0; gap = 0; len_err = 0; gap_err = 0;
        idle_err = 0; clk_total = 0; low_len = 0; done_cnt = 0; mcnt = 0; pix_err = 0;
        prev_href = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                pix[y][x] = 16'h1234;
                msk[y][x] = 1'b0;
            end
        t = 0;
        while (vid.frame_vsync === 1'b1 && t < 1000) begin
            vs_len++;
            if (vid.frame_done) done_cnt++;
            if (vid.frame_href) begin
                if (!prev_href) begin
                    if (gap != ((lines == 0) ? VF : HB)) gap_err++;
                    if (lines == stop_line) gen_en = 1'b0;
                    lines++;
                    hlen = 0;
                    xi   = 0;
                end
                hlen++;
                if (vid.frame_clken) begin
                    if (lines <= H && xi < W) begin
                        pix[lines-1][xi] = vid.frame_data;
                        msk[lines-1][xi] = vid.frame_mask;
                    end
                    xi++;
                    clk_total++;
                end
            end else begin
                if (prev_href) begin
                    if (hlen != W) len_err++;
                    gap = 0;
                end
                gap++;
                if (vid.frame_clken || vid.frame_mask || vid.frame_data != 16'h0) idle_err++;
            end
            prev_href = vid.frame_href;
            @(negedge clk);
            t++;
        end
        chk("done_first", 32'(vid.frame_done), 1);
        lim = expect_next ? 200 : 60;
        while (vid.frame_vsync !== 1'b1 && low_len < lim) begin
            if (vid.frame_done) done_cnt++;
            low_len++;
            @(negedge clk);
        end
        if (expect_next) begin
            chk("vblank_len", low_len, 10);
            chk("period", vs_len + low_len, 172);
        end else begin
            chk("idle_hold", low_len, 60);
        end
        chk("vs_len", vs_len, 162);
        chk("lines", lines, 8);
        chk("href_len_err", len_err, 0);
        chk("gap_err", gap_err, 0);
        chk("tail_gap", gap, 3);
        chk("idle_err", idle_err, 0);
        chk("clken_total", clk_total, 128);
        chk("done_cnt", done_cnt, 1);
        bx = exp_bx[fidx];
        by = exp_by[fidx];
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                em  = (x >= bx) && (x < bx + BOX) && (y >= by) && (y < by + BOX);
                bar = (x / 2 > 7) ? 7 : x / 2;
                ed  = em ? 16'hFFFF : colours[bar];
                if (msk[y][x] !== em || pix[y][x] !== ed) pix_err++;
                if (msk[y][x]) mcnt++;
            end
        chk("mask_cnt", mcnt, 16);
        chk("pix_err", pix_err, 0);
        chk("row0_x15", 32'(pix[0][15]), 0);
    endtask

    initial begin
        int t;
        rst_n  = 1'b0;
        gen_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", all_outs(), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_vsync", 32'(vid.frame_vsync), 0);
        gen_en = 1'b1;
        for (int f = 0; f < 8; f++) run_frame(f, -1, 1'b1);
        run_frame(8, 3, 1'b0);

        gen_en = 1'b1;
        t = 0;
        while (vid.frame_href !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("href_seen", 32'(vid.frame_href), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", all_outs(), 0);
        @(negedge clk);
        chk("rst_hold", all_outs(), 0);
        rst_n = 1'b1;
        run_frame(0, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
